usb_in_scheduler: RTL and testbench
===================================

Name: usb_in_scheduler

Overview:
- Sequences the device transmit path for IN transactions.
- Takes decoded IN tokens from the packet decoder and picks the responding endpoint and its response PID (DATA0/DATA1/NAK/STALL).
- Enforces bus turnaround, starts the shared packet transmitter, then waits for the host ACK with timeout.
- Owns the per-endpoint data toggle bits. Sits between the packet decoder, the endpoint buffers and the transmitter inside the USB full-speed top level (48 MHz domain, 4 clocks per bit).

Parameters:
NUM_EP, 4, number of IN endpoints (1..15); endpoint numbers >= NUM_EP are answered with STALL
TURNAROUND_CYCLES, 12, clk48 cycles from token acceptance to tx_start (3 bit times)
ACK_TIMEOUT_CYCLES, 80, clk48 cycles to wait for a handshake after own data packet ends (~20 bit times)

Ports:
clk48  in  1  system clock, 48 MHz
reset  in  1  asynchronous, active-high reset
bus_reset  in  1  USB bus reset detected (level); synchronous clear
tok_valid  in  1  one-cycle pulse: IN token for this device address decoded, CRC good
tok_ep  in  4  endpoint number qualified by tok_valid or setup_seen
setup_seen  in  1  one-cycle pulse: SETUP token accepted for tok_ep
ep_ready  in  NUM_EP  per endpoint: a packet is loaded and ready to send
ep_stall  in  NUM_EP  per endpoint: endpoint halted
tx_busy  in  1  transmitter is sending; rises the cycle after tx_start
hs_valid  in  1  one-cycle pulse: handshake packet received
hs_pid  in  4  PID of received handshake, qualified by hs_valid
tx_start  out  1  one-cycle pulse: transmitter begins packet
tx_pid  out  4  PID to send: DATA0=4'h3, DATA1=4'hB, NAK=4'hA, STALL=4'hE; held from selection until return to IDLE
ep_sel  out  4  endpoint whose buffer feeds the transmitter; held like tx_pid
ep_done  out  NUM_EP  one-cycle pulse on bit ep: packet ACKed, buffer may be released
idle  out  1  high in IDLE state

Behaviour:
- Reset (async) and bus_reset (sync, highest priority):
  - Next state IDLE; all toggles 0; tx_start=0, tx_pid=0, ep_sel=0, ep_done=0, idle=1; counters 0.
  - A bus_reset during any state aborts the transaction, with no ep_done and no toggle change.
- States: IDLE, TURN, SEND, WAIT_TX, WAIT_ACK.
- IDLE, on tok_valid:
  - Latch ep = tok_ep into ep_sel.
  - Select PID in priority order: ep >= NUM_EP -> STALL; ep_stall[ep] -> STALL; ep_ready[ep] -> DATA0/DATA1 per toggle[ep]; else NAK.
  - Load counter = TURNAROUND_CYCLES-1; go to TURN.
  - The PID is decided at token time; later ep_ready/ep_stall changes are ignored.
- TURN: decrement counter each cycle; at 0 go to SEND. tx_start therefore asserts exactly TURNAROUND_CYCLES+1 cycles after the tok_valid cycle.
- SEND: tx_start=1 for this single cycle; go to WAIT_TX; clear seen_busy flag.
- WAIT_TX:
  - Set seen_busy when tx_busy=1. Exit when seen_busy and tx_busy=0.
  - On exit: NAK/STALL -> IDLE. DATAx -> WAIT_ACK, counter = ACK_TIMEOUT_CYCLES-1.
- WAIT_ACK:
  - hs_valid with hs_pid=4'h2 (ACK): toggle[ep] flips, ep_done[ep] pulses next cycle, go to IDLE.
  - hs_valid with any other PID, or counter reaching 0: IDLE, no toggle flip, no ep_done. The packet stays loaded for retry.
  - tok_valid arrives (lost ACK, host retry): treat as timeout and process the token in the same cycle exactly as from IDLE. The same toggle is used, so identical data is resent.
- Tokens (tok_valid) in TURN, SEND or WAIT_TX are ignored. hs_valid outside WAIT_ACK is ignored.
- setup_seen in any state: toggle[tok_ep] <= 1 (ignored if tok_ep >= NUM_EP); does not change FSM state.
  - setup_seen and an ACK flip on the same endpoint in the same cycle: setup wins (toggle=1).
- tx_pid and ep_sel are cleared to 0 on entry to IDLE. At most one ep_done bit is ever set.

Test Plan:
- ep_ready=4'b0010, toggle reset, IN ep1 -> tx_start exactly 13 cycles after tok_valid, tx_pid=4'h3, ep_sel=1. ACK within 80 cycles after tx_busy falls -> ep_done=4'b0010 for 1 cycle. Second IN ep1 -> tx_pid=4'hB.
- ep_ready=0, IN ep2 -> tx_pid=4'hA, return to IDLE after tx_busy falls, no ep_done, toggle[2] unchanged. ep_stall[2]=1 -> 4'hE. IN ep7 with NUM_EP=4 -> 4'hE.
- DATA0 sent on ep1, no handshake -> idle=1 exactly 80 cycles after tx_busy falls, no ep_done. Next IN ep1 -> DATA0 again.
- DATA1 sent, new IN token during WAIT_ACK -> token accepted that cycle, resend with DATA1, no ep_done.
- setup_seen ep0, then IN ep0 with ep_ready[0]=1 -> DATA1. setup_seen coincident with ACK on ep0 -> next PID DATA1.
- bus_reset asserted mid-TURN with toggle[1]=1 -> no tx_start, idle=1 next cycle, next IN ep1 -> DATA0. Async reset mid-WAIT_ACK -> all outputs 0, idle=1 immediately.

Source files
------------

// File: rtl/usb_in_scheduler.sv
// usb_in_scheduler: sequences the device transmit path for USB full-speed IN
// transactions. A decoded IN token selects an endpoint and response PID
// (DATA0/DATA1/NAK/STALL). After bus turnaround the shared transmitter is
// started. For data packets the host handshake is then awaited, with a timeout.
// The per-endpoint data toggle bits are kept here.
//
// Ports:
//   clk48_i       48 MHz system clock
//   reset_i       asynchronous active-high reset
//   bus_reset_i   USB bus reset (level), synchronous clear, highest priority
//   tok_valid_i   one-cycle pulse: IN token for this device decoded
//   tok_ep_i      endpoint number qualified by tok_valid_i / setup_seen_i
//   setup_seen_i  one-cycle pulse: SETUP token accepted for tok_ep_i
//   ep_ready_i    per endpoint: packet loaded and ready to send
//   ep_stall_i    per endpoint: endpoint halted
//   tx_busy_i     transmitter busy; rises the cycle after tx_start_o
//   hs_valid_i    one-cycle pulse: handshake packet received
//   hs_pid_i      handshake PID, qualified by hs_valid_i
//   tx_start_o    one-cycle pulse: start transmitting a packet
//   tx_pid_o      PID to send, held from selection until return to idle
//   ep_sel_o      endpoint feeding the transmitter, held like tx_pid_o
//   ep_done_o     one-cycle pulse on the endpoint whose packet was ACKed
//   idle_o        high while idle
module usb_in_scheduler #(
    parameter int unsigned NUM_EP             = 4,
    parameter int unsigned TURNAROUND_CYCLES  = 12,
    parameter int unsigned ACK_TIMEOUT_CYCLES = 80
) (
    input  logic              clk48_i,
    input  logic              reset_i,
    input  logic              bus_reset_i,
    input  logic              tok_valid_i,
    input  logic [3:0]        tok_ep_i,
    input  logic              setup_seen_i,
    input  logic [NUM_EP-1:0] ep_ready_i,
    input  logic [NUM_EP-1:0] ep_stall_i,
    input  logic              tx_busy_i,
    input  logic              hs_valid_i,
    input  logic [3:0]        hs_pid_i,
    output logic              tx_start_o,
    output logic [3:0]        tx_pid_o,
    output logic [3:0]        ep_sel_o,
    output logic [NUM_EP-1:0] ep_done_o,
    output logic              idle_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StTurn    = 3'd1;
    localparam logic [2:0] StSend    = 3'd2;
    localparam logic [2:0] StWaitTx  = 3'd3;
    localparam logic [2:0] StWaitAck = 3'd4;

    localparam logic [3:0] PidData0 = 4'h3;
    localparam logic [3:0] PidData1 = 4'hB;
    localparam logic [3:0] PidNak   = 4'hA;
    localparam logic [3:0] PidStall = 4'hE;
    localparam logic [3:0] PidAck   = 4'h2;

    localparam int unsigned CntMax = (TURNAROUND_CYCLES > ACK_TIMEOUT_CYCLES) ?
                                     TURNAROUND_CYCLES : ACK_TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] TurnLoad = CntW'(TURNAROUND_CYCLES - 1);
    localparam logic [CntW-1:0] AckLoad  = CntW'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      NumEpW   = 5'(NUM_EP);

    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        pid_q, pid_d;
    logic [3:0]        sel_q, sel_d;
    logic              seen_q, seen_d;
    logic [NUM_EP-1:0] toggle_q, toggle_d;
    logic [NUM_EP-1:0] done_q, done_d;

    logic       tok_in_range;
    logic       tok_ready;
    logic       tok_stall;
    logic       tok_toggle;
    logic [3:0] tok_pid;
    logic       accept_tok;
    logic       go_idle;
    logic       pid_is_data;

    // Per-endpoint lookups for the token endpoint; out-of-range numbers match no bit.
    always_comb begin
        tok_ready  = 1'b0;
        tok_stall  = 1'b0;
        tok_toggle = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (tok_ep_i == 4'(i)) begin
                tok_ready  = ep_ready_i[i];
                tok_stall  = ep_stall_i[i];
                tok_toggle = toggle_q[i];
            end
        end
    end

    assign tok_in_range = ({1'b0, tok_ep_i} < NumEpW);
    assign pid_is_data  = (pid_q == PidData0) || (pid_q == PidData1);

    always_comb begin
        if (!tok_in_range || tok_stall) begin
            tok_pid = PidStall;
        end else if (tok_ready) begin
            tok_pid = tok_toggle ? PidData1 : PidData0;
        end else begin
            tok_pid = PidNak;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pid_d      = pid_q;
        sel_d      = sel_q;
        seen_d     = seen_q;
        toggle_d   = toggle_q;
        done_d     = '0;
        accept_tok = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            StIdle: begin
                accept_tok = tok_valid_i;
            end
            StTurn: begin
                if (cnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StSend: begin
                state_d = StWaitTx;
                seen_d  = 1'b0;
            end
            StWaitTx: begin
                // Only a high-then-low tx_busy marks the end of our own packet.
                if (tx_busy_i) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    if (pid_is_data) begin
                        state_d = StWaitAck;
                        cnt_d   = AckLoad;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
            StWaitAck: begin
                // A new token here means the host never saw our data: retry
                // with the unchanged toggle.
                if (tok_valid_i) begin
                    accept_tok = 1'b1;
                end else if (hs_valid_i) begin
                    if (hs_pid_i == PidAck) begin
                        for (int i = 0; i < NUM_EP; i++) begin
                            if (sel_q == 4'(i)) begin
                                toggle_d[i] = ~toggle_q[i];
                                done_d[i]   = 1'b1;
                            end
                        end
                    end
                    go_idle = 1'b1;
                end else if (cnt_q == '0) begin
                    go_idle = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d = StIdle;
            pid_d   = 4'h0;
            sel_d   = 4'h0;
            cnt_d   = '0;
        end

        if (accept_tok) begin
            state_d = StTurn;
            sel_d   = tok_ep_i;
            pid_d   = tok_pid;
            cnt_d   = TurnLoad;
        end

        // SETUP resets the toggle to DATA1 and overrides a simultaneous ACK flip.
        if (setup_seen_i) begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (tok_ep_i == 4'(i)) begin
                    toggle_d[i] = 1'b1;
                end
            end
        end

        if (bus_reset_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            pid_d    = 4'h0;
            sel_d    = 4'h0;
            seen_d   = 1'b0;
            toggle_d = '0;
            done_d   = '0;
        end
    end

    always_ff @(posedge clk48_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pid_q    <= 4'h0;
            sel_q    <= 4'h0;
            seen_q   <= 1'b0;
            toggle_q <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pid_q    <= pid_d;
            sel_q    <= sel_d;
            seen_q   <= seen_d;
            toggle_q <= toggle_d;
            done_q   <= done_d;
        end
    end

    assign tx_start_o = (state_q == StSend);
    assign idle_o     = (state_q == StIdle);
    assign tx_pid_o   = pid_q;
    assign ep_sel_o   = sel_q;
    assign ep_done_o  = done_q;

endmodule

// File: tb/tb_usb_in_scheduler.sv
// Directed bench for usb_in_scheduler: expected PID/endpoint pairs are queued
// when a token is driven and compared when tx_start appears.
module tb_usb_in_scheduler;

    logic       clk48 = 1'b0;
    logic       reset = 1'b0;
    logic       bus_reset = 1'b0;
    logic       tok_valid = 1'b0;
    logic [3:0] tok_ep = 4'h0;
    logic       setup_seen = 1'b0;
    logic [3:0] ep_ready = 4'h0;
    logic [3:0] ep_stall = 4'h0;
    logic       tx_busy = 1'b0;
    logic       hs_valid = 1'b0;
    logic [3:0] hs_pid = 4'h0;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [3:0] ep_sel;
    logic [3:0] ep_done;
    logic       idle;

    typedef struct packed {
        logic [3:0] pid;
        logic [3:0] ep;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cycles = 0;
    int   start_cnt = 0;

    usb_in_scheduler #(
        .NUM_EP(4),
        .TURNAROUND_CYCLES(12),
        .ACK_TIMEOUT_CYCLES(80)
    ) dut (
        .clk48_i(clk48),
        .reset_i(reset),
        .bus_reset_i(bus_reset),
        .tok_valid_i(tok_valid),
        .tok_ep_i(tok_ep),
        .setup_seen_i(setup_seen),
        .ep_ready_i(ep_ready),
        .ep_stall_i(ep_stall),
        .tx_busy_i(tx_busy),
        .hs_valid_i(hs_valid),
        .hs_pid_i(hs_pid),
        .tx_start_o(tx_start),
        .tx_pid_o(tx_pid),
        .ep_sel_o(ep_sel),
        .ep_done_o(ep_done),
        .idle_o(idle)
    );

    always #5 clk48 = ~clk48;

    always @(posedge clk48) begin
        if (ep_done != 4'h0) done_cycles <= done_cycles + 1;
        if (tx_start) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the token.
    task automatic send_in(input logic [3:0] ep, input logic [3:0] pid, input bit push);
        exp_t e;
        e.pid = pid;
        e.ep  = ep;
        if (push) sb_q.push_back(e);
        tok_valid = 1'b1;
        tok_ep    = ep;
        @(negedge clk48);
        tok_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!tx_start && lat < 40) begin
            @(negedge clk48);
            lat++;
        end
        chk({tag, "_latency"}, lat, 13);
        chk({tag, "_sb_nonempty"}, (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_pid"}, tx_pid, e.pid);
            chk({tag, "_ep_sel"}, ep_sel, e.ep);
        end
    endtask

    // Returns at the negedge right after the first clock edge that sees tx_busy low.
    task automatic xfer();
        tx_busy = 1'b1;
        repeat (4) @(negedge clk48);
        tx_busy = 1'b0;
        @(negedge clk48);
    endtask

    task automatic ack();
        hs_valid = 1'b1;
        hs_pid   = 4'h2;
        @(negedge clk48);
        hs_valid = 1'b0;
    endtask

    initial begin
        int k;
        int d0;
        int s0;

        // Async reset
        #1 reset = 1'b1;
        #1;
        chk("rst_idle", idle, 1);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_pid", tx_pid, 0);
        chk("rst_ep_sel", ep_sel, 0);
        chk("rst_ep_done", ep_done, 0);
        @(negedge clk48);
        @(negedge clk48);
        reset = 1'b0;
        @(negedge clk48);

        // DATA0 on ep1, ACKed, then DATA1
        ep_ready = 4'b0010;
        send_in(4'd1, 4'h3, 1'b1);
        wait_start("ep1_d0");
        xfer();
        chk("ep1_d0_hold_pid", tx_pid, 4'h3);
        repeat (10) @(negedge clk48);
        ack();
        chk("ep1_done_bit", ep_done, 4'b0010);
        chk("ep1_ack_idle", idle, 1);
        @(negedge clk48);
        chk("ep1_done_clear", ep_done, 4'h0);
        chk("ep1_pid_clear", tx_pid, 4'h0);
        chk("ep1_done_cycles", done_cycles, 1);
        send_in(4'd1, 4'hB, 1'b1);
        wait_start("ep1_d1");
        xfer();
        ack();
        @(negedge clk48);
        chk("ep1_d1_done_cycles", done_cycles, 2);

        // NAK, STALL, out-of-range STALL
        ep_ready = 4'b0000;
        send_in(4'd2, 4'hA, 1'b1);
        wait_start("ep2_nak");
        xfer();
        chk("nak_idle", idle, 1);
        chk("nak_pid_clear", tx_pid, 4'h0);
        ep_stall = 4'b0100;
        send_in(4'd2, 4'hE, 1'b1);
        wait_start("ep2_stall");
        xfer();
        chk("stall_idle", idle, 1);
        ep_stall = 4'b0000;
        send_in(4'd7, 4'hE, 1'b1);
        wait_start("ep7_stall");
        xfer();
        chk("ep7_idle", idle, 1);
        chk("nak_stall_no_done", done_cycles, 2);

        // ep2 toggle untouched by NAK/STALL
        ep_ready = 4'b0110;
        send_in(4'd2, 4'h3, 1'b1);
        wait_start("ep2_d0");
        xfer();
        ack();
        @(negedge clk48);

        // ACK timeout on ep1
        send_in(4'd1, 4'h3, 1'b1);
        wait_start("ep1_to");
        xfer();
        d0 = done_cycles;
        k = 0;
        while (!idle && k < 200) begin
            @(negedge clk48);
            k++;
        end
        chk("ack_timeout_cycles", k, 80);
        chk("timeout_no_done", done_cycles, d0);
        send_in(4'd1, 4'h3, 1'b1);
        wait_start("ep1_after_to");
        xfer();
        ack();
        @(negedge clk48);

        // Lost ACK: host retries during WAIT_ACK with the same toggle
        send_in(4'd1, 4'hB, 1'b1);
        wait_start("ep1_d1_first");
        xfer();
        d0 = done_cycles;
        repeat (5) @(negedge clk48);
        send_in(4'd1, 4'hB, 1'b1);
        wait_start("ep1_retry");
        chk("retry_no_done", done_cycles, d0);
        xfer();
        ack();
        @(negedge clk48);

        // SETUP forces DATA1 on ep0
        ep_ready   = 4'b0111;
        setup_seen = 1'b1;
        tok_ep     = 4'd0;
        @(negedge clk48);
        setup_seen = 1'b0;
        send_in(4'd0, 4'hB, 1'b1);
        wait_start("ep0_setup_d1");
        xfer();
        ack();
        @(negedge clk48);
        send_in(4'd0, 4'h3, 1'b1);
        wait_start("ep0_d0");
        xfer();
        d0 = done_cycles;
        hs_valid   = 1'b1;
        hs_pid     = 4'h2;
        setup_seen = 1'b1;
        tok_ep     = 4'd0;
        @(negedge clk48);
        hs_valid   = 1'b0;
        setup_seen = 1'b0;
        chk("setup_ack_done", ep_done, 4'b0001);
        @(negedge clk48);
        chk("setup_ack_done_cycles", done_cycles, d0 + 1);
        send_in(4'd0, 4'hB, 1'b1);
        wait_start("ep0_setup_wins");
        xfer();
        ack();
        @(negedge clk48);

        // bus_reset mid-TURN clears toggles and aborts
        send_in(4'd1, 4'h3, 1'b1);
        wait_start("ep1_pre_busreset");
        xfer();
        ack();
        @(negedge clk48);
        d0 = done_cycles;
        send_in(4'd1, 4'hB, 1'b0);
        repeat (4) @(negedge clk48);
        chk("turn_not_idle", idle, 0);
        s0 = start_cnt;
        bus_reset = 1'b1;
        @(negedge clk48);
        chk("busreset_idle", idle, 1);
        chk("busreset_pid", tx_pid, 4'h0);
        bus_reset = 1'b0;
        repeat (20) @(negedge clk48);
        chk("busreset_no_start", start_cnt, s0);
        chk("busreset_no_done", done_cycles, d0);
        send_in(4'd1, 4'h3, 1'b1);
        wait_start("ep1_after_busreset");
        xfer();

        // Async reset in WAIT_ACK
        repeat (3) @(negedge clk48);
        chk("waitack_not_idle", idle, 0);
        #1 reset = 1'b1;
        #1;
        chk("areset_idle", idle, 1);
        chk("areset_pid", tx_pid, 4'h0);
        chk("areset_ep_sel", ep_sel, 4'h0);
        chk("areset_tx_start", tx_start, 0);
        chk("areset_ep_done", ep_done, 4'h0);
        @(negedge clk48);
        reset = 1'b0;
        @(negedge clk48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
